// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered adder among NREQ requesters.
// Optional carry-out reporting on rsp_ovf is enabled by defining ADDER_ARB_OVF_EN.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int IDW   = 2
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_flat,
    input  logic [NREQ*WIDTH-1:0] b_flat,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_result,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_ovf,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b;
    logic [IDW-1:0]   id_q, rr_ptr, win;
    logic             found;
    logic [IDW:0]     cand;

    // Search upward from the slot after the last winner, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state     <= IDLE;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            rr_ptr    <= IDW'(NREQ-1);
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    gnt    <= NREQ'(1) << win;
                    op_a   <= a_flat[win*WIDTH +: WIDTH];
                    op_b   <= b_flat[win*WIDTH +: WIDTH];
                    id_q   <= win;
                    rr_ptr <= win;
                    state  <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    rsp_data  <= add_result;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign add_a = op_a;
    assign add_b = op_b;
    assign busy  = (state != IDLE);

`ifdef ADDER_ARB_OVF_EN
    // op_a/op_b are still held in WAIT, so the carry is recomputed locally.
    logic [WIDTH:0] wide_sum;
    assign wide_sum = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge iclk) begin
        if (irst)
            rsp_ovf <= 1'b0;
        else
            rsp_ovf <= (state == WAIT) && wide_sum[WIDTH];
    end
`else
    assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed plan steps plus random
// traffic against a schedule-based reference model; also models the shared adder.
module tb_adder_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int IDW   = 2;
`ifdef ADDER_ARB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                  iclk = 1'b0;
    logic                  irst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_flat, b_flat;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      add_a, add_b, add_result;
    logic                  rsp_valid, rsp_ovf, busy;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .iclk(iclk), .irst(irst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 iclk = ~iclk;

    // Shared registered adder, same clock and reset as the arbiter.
    always @(posedge iclk) begin
        if (irst) add_result <= '0;
        else      add_result <= add_a + add_b;
    end

    int n_vec = 0, n_bad = 0;
    int cyc = 0, idle_from = 0, gnt_at = -10, rsp_at = -10, last = NREQ-1;
    bit auto_drop = 1'b1;
    logic [WIDTH-1:0] exp_a, exp_b, exp_sum;
    logic exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock; the model schedules grant/response cycles from the
    // values the DUT sampled on that edge, then every output is checked.
    task automatic tick();
        logic [NREQ-1:0]       rq;
        logic [NREQ*WIDTH-1:0] av, bv;
        logic                  rs;
        int c, w, s;
        bit hit;
        rq = req; av = a_flat; bv = b_flat; rs = irst; c = cyc;
        @(posedge iclk); #1;
        cyc++;
        if (rs) begin
            last = NREQ-1; idle_from = cyc; gnt_at = -10; rsp_at = -10;
        end else if (c >= idle_from && rq != '0) begin
            hit = 1'b0; w = 0;
            for (int k = 1; k <= NREQ; k++)
                if (!hit && rq[(last + k) % NREQ]) begin hit = 1'b1; w = (last + k) % NREQ; end
            last = w;
            gnt_at = c + 1; rsp_at = c + 3; idle_from = c + 3;
            exp_a = av[w*WIDTH +: WIDTH];
            exp_b = bv[w*WIDTH +: WIDTH];
            s = int'(exp_a) + int'(exp_b);
            exp_sum = WIDTH'(s % (1 << WIDTH));
            exp_ovf = (s >= (1 << WIDTH));
        end
        chk("gnt", 32'(gnt), (cyc == gnt_at) ? (32'd1 << last) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
        chk("busy", 32'(busy), 32'(cyc < idle_from));
        if (cyc == rsp_at) begin
            chk("rsp_id", 32'(rsp_id), 32'(last));
            chk("rsp_data", 32'(rsp_data), 32'(exp_sum));
            chk("rsp_ovf", 32'(rsp_ovf), 32'(OVF_EN & exp_ovf));
        end else begin
            chk("rsp_ovf_idle", 32'(rsp_ovf), 32'd0);
        end
        if (rs) begin
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        end
        if (cyc == gnt_at || cyc == gnt_at + 1) begin
            chk("add_a", 32'(add_a), 32'(exp_a));
            chk("add_b", 32'(add_b), 32'(exp_b));
        end
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic drain();
        req = '0;
        repeat (4) tick();
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        a_flat[i*WIDTH +: WIDTH] = WIDTH'(a);
        b_flat[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    initial begin
        a_flat = '0; b_flat = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);

        // Reset held two cycles with all requests high.
        irst = 1'b1; req = '1;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        irst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'b0001);
        drain();

        // Single op from requester 2.
        set_ops(2, 3, 2); req = 4'b0100;
        tick(); chk("single_gnt", 32'(gnt), 32'b0100);
        tick(); tick();
        chk("single_vld", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_data", 32'(rsp_data), 32'd5);
        drain();

        // Modulo wrap 7+1.
        set_ops(1, 7, 1); req = 4'b0010;
        repeat (3) tick();
        chk("wrap_data", 32'(rsp_data), 32'd0);
        chk("wrap_ovf", 32'(rsp_ovf), 32'(OVF_EN));
        drain();

        // Fairness with all requests held, starting from reset priority.
        irst = 1'b1; tick();
        irst = 1'b0; req = '1; auto_drop = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            chk("fair_gnt", 32'(gnt), 32'd1 << (n % NREQ));
            if (n < 4) repeat (3) tick();
        end
        auto_drop = 1'b1;
        drain();

        // Request arriving while busy.
        set_ops(0, $urandom, $urandom); req = 4'b0001;
        tick(); tick();
        set_ops(3, $urandom, $urandom); req[3] = 1'b1;
        tick(); tick();
        chk("busy_gnt3", 32'(gnt), 32'b1000);
        tick(); tick();
        chk("busy_vld", 32'(rsp_valid), 32'd1);
        chk("busy_id", 32'(rsp_id), 32'd3);
        drain();

        // Reset in the middle of an operation.
        set_ops(2, $urandom, $urandom); req = 4'b0100;
        tick(); tick();
        irst = 1'b1;
        tick();
        chk("midrst_vld", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        irst = 1'b0; req = 4'b0011;
        tick();
        chk("midrst_gnt", 32'(gnt), 32'b0001);
        drain();

        // Random traffic with occasional resets.
        repeat (400) begin
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_ops(i, $urandom, $urandom);
                    req[i] = 1'b1;
                end
            irst = ($urandom_range(0, 59) == 0);
            tick();
        end
        irst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered WIDTH-bit adder (1-cycle latency, synchronous active-high reset) among NREQ requesters.
- Round-robin arbitration; latches the winner's operands, drives the adder, captures the sum and returns it tagged with the requester ID.
- Sits between requester blocks and the adder instance; the adder and this block use the same clock and reset.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 3, operand/result width; must match the adder.
- IDW, 2, requester ID width; must be at least clog2(NREQ).

Ports:
- iclk  in  1  clock, rising edge.
- irst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request level.
- a_flat  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- b_flat  in  NREQ*WIDTH  operand B, same packing as a_flat.
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- add_a  out  WIDTH  operand A to adder.
- add_b  out  WIDTH  operand B to adder.
- add_result  in  WIDTH  registered sum from adder.
- rsp_valid  out  1  result pulse, 1 cycle.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  WIDTH  result.
- rsp_ovf  out  1  carry-out flag (see Optional Feature).
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, iclk. irst is synchronous and active-high.
- Reset values: state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0, op_a=0, op_b=0, rr_ptr=NREQ-1, busy=0.
- Adder drive: add_a=op_a and add_b=op_b, driven directly from registers. Both are held stable from ISSUE through WAIT.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: pick the first asserted req searching from (rr_ptr+1) mod NREQ upward with wrap. At the next edge:
  - gnt = one-hot of winner.
  - op_a/op_b <= winner's operands; id_q <= winner; rr_ptr <= winner.
  - state <= ISSUE.
- ISSUE: gnt <= 0. The adder registers op_a+op_b at the end of this cycle. state <= WAIT.
- WAIT: add_result is valid. At the next edge:
  - rsp_data <= add_result, rsp_id <= id_q, rsp_valid <= 1.
  - state <= IDLE.
- rsp_valid drops after 1 cycle unless another response is due.
- Latency: req sampled in cycle 0, gnt high in cycle 1, rsp_valid high in cycle 3.
- Throughput: the IDLE in cycle 3 can sample a new req, so the next gnt comes in cycle 4 (one operation per 3 cycles).
- req is sampled only in IDLE. A requester holds req and its operands until it sees gnt, then deasserts req in the next cycle. A req still high when IDLE is re-entered counts as a new request.
- Requests arriving while busy are not lost; they wait until IDLE.
- Simultaneous requests: round-robin order. Each requester is served at most once per NREQ grants while the others keep requesting.
- Arithmetic: sum is modulo 2^WIDTH. Example with WIDTH=3: 7+1 gives 0.
- Reset mid-operation: the in-flight op is discarded, no rsp_valid is produced, and the adder is also reset. After reset, requester 0 has top priority.
- gnt and rsp_valid are never high for more than 1 consecutive cycle for the same operation.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- Defined: at the WAIT edge, rsp_ovf <= (op_a + op_b >= 2^WIDTH), computed internally at WIDTH+1 bits. rsp_ovf is valid with rsp_valid and is 0 otherwise.
- Not defined: rsp_ovf is tied to 0 and the extra logic is absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert irst 2 cycles with req=4'b1111. -> gnt=0, rsp_valid=0, busy=0 throughout. After release, first gnt=4'b0001.
- Single op: req[2]=1, a=3, b=2, all other req=0, sampled cycle 0. -> gnt=4'b0100 in cycle 1; rsp_valid=1, rsp_id=2, rsp_data=5 in cycle 3.
- Wrap: req[1] with a=7, b=1. -> rsp_data=0. rsp_ovf=1 with ADDER_ARB_OVF_EN defined; rsp_ovf=0 without it.
- Fairness: req=4'b1111 held (re-asserted after each gnt). -> grant order 0,1,2,3,0 at cycles 1,4,7,10,13; rsp_id follows the same order.
- Request while busy: req[3] asserted in cycle 2 while req[0] op is in flight. -> gnt[3] in cycle 4; rsp_id=3 in cycle 6.
- Mid-op reset: irst asserted in cycle 2 of an op. -> no rsp_valid in cycle 3, state IDLE, rr_ptr reset so req0 wins next.
